fp_normalizer: RTL and testbench
================================

Name: fp_normalizer

Overview:
- Post-add normalization stage of the FPU single-precision adder.
- Consumes the 25-bit raw mantissa sum (carry bit plus 24 bits, hidden bit at position 23), the pre-normalization exponent and the sign.
- Locates the leading one, shifts the mantissa into 1.f form, adjusts the exponent, and flags overflow and underflow.
- Two-stage pipeline with valid/ready handshake; feeds the packing/writeback stage.

Parameters:
- MANT_W, 25, raw mantissa width including carry bit (hidden-bit position = MANT_W-2).
- EXP_W, 8, exponent width.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  input beat valid
- in_ready  output  1  stage accepts a beat this cycle
- in_sign  input  1  sign of the sum
- in_exp  input  EXP_W  biased exponent before normalization
- in_mant  input  MANT_W  raw mantissa sum [24:0]
- in_sticky  input  1  OR of bits shifted out during alignment
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts
- out_sign  output  1  result sign
- out_exp  output  EXP_W  normalized biased exponent
- out_frac  output  MANT_W-2  fraction [22:0], hidden bit dropped
- out_ovf  output  1  result saturated to infinity
- out_unf  output  1  result flushed to zero

Behaviour:
- Reset: all stage valids 0. out_valid=0, out_sign=0, out_exp=0, out_frac=0, out_ovf=0, out_unf=0. in_ready=1 after reset.
- Clock and reset: one clock; reset is asynchronous and active-high.
- Pipeline, latency 2 cycles (accept edge to out_valid):
  - S1 registers inputs and msb_index (leading-one position 0..24, 0 when mant==0).
  - S2 registers the shifted and adjusted result.
- Handshake:
  - advance = !out_valid | out_ready.
  - in_ready = advance | !s1_valid.
  - S1 loads on in_valid & in_ready; S2 loads when advance.
  - Both stages hold contents while stalled.
  - out_* stable while out_valid & !out_ready.
  - Full throughput: one beat per cycle when out_ready stays high.
- S2 arithmetic, decided in this priority order:
  1. in_exp==all-ones: pass-through (inf/NaN). exp=255, frac=mant[22:0], flags 0.
  2. mant==0: exp=0, frac=0, sign=in_sign, unf=0.
  3. msb_index==24: mant>>1, exp+1. If the result exp==255: exp=255, frac=0, ovf=1.
  4. msb_index==23: unchanged.
  5. msb_index<23: shift = 23-msb_index; mant<<shift. If in_exp <= shift: exp=0, frac=0, unf=1, sign kept. Otherwise exp = in_exp - shift.
- Exponent math is done at EXP_W+1 bits so that wrap-around cannot occur.
- Reset mid-operation discards both stages; no partial beat is emitted.

Optional Feature:
- Macro: FP_NORM_ROUND_NEAREST_EN.
- Defined: round-to-nearest-even after normalization.
  - guard = bit shifted out on the right shift (else 0).
  - sticky = in_sticky.
  - Increment when guard & (sticky | frac[0]).
  - If the increment carries out of the 24-bit significand: frac=0, exp+1, re-check overflow (exp 255 gives ovf=1).
  - Latency stays 2.
- Undefined: truncation; in_sticky is ignored.

Decomposition:
- Package fp_pkg: EXP_W, FRAC_W=23, EXP_MAX=255, bias 127, and the fp_sp struct typedef {sign, exp, frac}.
- Sub-module: priority_coder (word_size=MANT_W), instantiated in S1 to produce msb_index.

Test Plan:
- mant=0x0800000, exp=100, sign=0 -> exp=100, frac=0, flags 0, out_valid exactly 2 cycles after accept.
- mant=0x1800000, exp=254 -> exp=255, frac=0, ovf=1. Same mant with exp=10 -> exp=11, frac=0x400000.
- mant=0x0000001, exp=30 (shift 23 >= 30? no) -> exp=7, frac=0. Then exp=23 -> unf=1, exp=0, frac=0.
- mant=0, exp=77, sign=1 -> exp=0, frac=0, sign=1, flags 0. Then exp=255, mant=0x0400001 -> pass-through, frac=0x400001.
- Back-to-back 8 beats with out_ready low for cycles 3-5 -> in_ready drops when full, no beat lost or duplicated, order preserved, outputs stable during stall.
- With FP_NORM_ROUND_NEAREST_EN defined: mant=0x1FFFFFF, exp=50, sticky=0 -> guard=1, frac LSB=1, round up carries out -> exp=52, frac=0. Assert rst mid-stream -> out_valid=0 immediately, asynchronously.

Source files
------------

// File: rtl/fp_pkg.sv
// -----------------------------------------------------------------------------
// fp_pkg
// Shared constants and types for the single-precision adder datapath.
//   EXP_W   : exponent width
//   FRAC_W  : stored fraction width (hidden bit excluded)
//   EXP_MAX : all-ones biased exponent (infinity / NaN encoding)
//   BIAS    : exponent bias
//   fp_sp   : packed {sign, exp, frac} single-precision result
// -----------------------------------------------------------------------------
package fp_pkg;

  localparam int EXP_W   = 8;
  localparam int FRAC_W  = 23;
  localparam int EXP_MAX = 255;
  localparam int BIAS    = 127;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [FRAC_W-1:0] frac;
  } fp_sp;

endpackage : fp_pkg

// File: rtl/priority_coder.sv
// -----------------------------------------------------------------------------
// priority_coder
// Combinational leading-one detector.
//   word      : input vector
//   msb_index : position of the most significant set bit (0 when word == 0)
// -----------------------------------------------------------------------------
module priority_coder #(
  parameter int WORD_SIZE = 25,
  parameter int IDX_W     = $clog2(WORD_SIZE)
) (
  input  logic [WORD_SIZE-1:0] word,
  output logic [IDX_W-1:0]     msb_index
);

  // NOTE: combinational logic uses blocking '=' and assigns a default first,
  // so every path drives msb_index and no latch is inferred.
  always_comb begin
    msb_index = '0;
    // Ascending scan: the last hit (highest set bit) wins.
    for (int i = 0; i < WORD_SIZE; i++) begin
      if (word[i]) msb_index = i[IDX_W-1:0];
    end
  end

endmodule : priority_coder

// File: rtl/fp_normalizer.sv
// -----------------------------------------------------------------------------
// fp_normalizer
// Post-add normalization stage of the single-precision FPU adder.
// Two-stage pipeline with valid/ready handshake, latency 2.
//   S1: registers the beat plus the leading-one position of the raw mantissa.
//   S2: shifts into 1.f form, adjusts the exponent, flags overflow/underflow.
// Ports:
//   clk, rst (async, active-high)
//   in_valid/in_ready, in_sign, in_exp, in_mant (carry + 24 bits), in_sticky
//   out_valid/out_ready, out_sign, out_exp, out_frac, out_ovf, out_unf
// Build option:
//   FP_NORM_ROUND_NEAREST_EN : round-to-nearest-even after normalization;
//   when undefined the result is truncated and in_sticky is ignored.
// -----------------------------------------------------------------------------
module fp_normalizer #(
  parameter int MANT_W = 25,
  parameter int EXP_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_sign,
  input  logic [EXP_W-1:0]  in_exp,
  input  logic [MANT_W-1:0] in_mant,
  input  logic              in_sticky,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_sign,
  output logic [EXP_W-1:0]  out_exp,
  output logic [MANT_W-3:0] out_frac,
  output logic              out_ovf,
  output logic              out_unf
);

  import fp_pkg::*;

  localparam int FW    = MANT_W - 2;          // fraction width == hidden-bit index
  localparam int IDX_W = $clog2(MANT_W);
  localparam logic [EXP_W-1:0] EXP_ONES = '1;
  localparam logic [EXP_W:0]   EXP_SAT  = (EXP_W+1)'(EXP_MAX);
  localparam logic [IDX_W-1:0] IDX_CARRY  = IDX_W'(MANT_W - 1);
  localparam logic [IDX_W-1:0] IDX_HIDDEN = IDX_W'(FW);

  // ---------------- S1 ----------------
  logic              s1_valid_q, s1_valid_d;
  logic              s1_sign_q,  s1_sign_d;
  logic [EXP_W-1:0]  s1_exp_q,   s1_exp_d;
  logic [MANT_W-1:0] s1_mant_q,  s1_mant_d;
  logic [IDX_W-1:0]  s1_idx_q,   s1_idx_d;
  logic [IDX_W-1:0]  pc_idx;
  logic              advance;
`ifdef FP_NORM_ROUND_NEAREST_EN
  logic              s1_sticky_q, s1_sticky_d;
`else
  logic              unused_sticky;
  assign unused_sticky = in_sticky;
`endif

  priority_coder #(.WORD_SIZE(MANT_W), .IDX_W(IDX_W)) u_priority_coder (
    .word      (in_mant),
    .msb_index (pc_idx)
  );

  always_comb begin
    advance    = !out_valid | out_ready;
    in_ready   = advance | !s1_valid_q;
    s1_valid_d = s1_valid_q;
    s1_sign_d  = s1_sign_q;
    s1_exp_d   = s1_exp_q;
    s1_mant_d  = s1_mant_q;
    s1_idx_d   = s1_idx_q;
`ifdef FP_NORM_ROUND_NEAREST_EN
    s1_sticky_d = s1_sticky_q;
`endif
    // When in_ready is high S1 is either empty or draining into S2 this cycle.
    if (in_ready) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_sign_d = in_sign;
        s1_exp_d  = in_exp;
        s1_mant_d = in_mant;
        s1_idx_d  = pc_idx;
`ifdef FP_NORM_ROUND_NEAREST_EN
        s1_sticky_d = in_sticky;
`endif
      end
    end
  end

  // ---------------- S2 arithmetic ----------------
  fp_sp             calc_res;
  logic             calc_ovf, calc_unf;
  logic [EXP_W:0]   exp_ext;         // one extra bit so +1 / -shift cannot wrap
  logic [IDX_W-1:0] shift;
  logic [FW-1:0]    frac_tmp;
  logic             round_carry;
`ifdef FP_NORM_ROUND_NEAREST_EN
  logic             round_up;
`endif

  always_comb begin
    calc_res      = '0;
    calc_res.sign = s1_sign_q;
    calc_ovf      = 1'b0;
    calc_unf      = 1'b0;
    exp_ext       = '0;
    shift         = '0;
    frac_tmp      = '0;
    round_carry   = 1'b0;
`ifdef FP_NORM_ROUND_NEAREST_EN
    round_up      = 1'b0;
`endif
    if (s1_exp_q == EXP_ONES) begin
      // Infinity / NaN pass straight through.
      calc_res.exp  = EXP_ONES;
      calc_res.frac = s1_mant_q[FW-1:0];
    end else if (s1_mant_q == '0) begin
      // Exact zero: exp and frac stay 0, no underflow.
    end else if (s1_idx_q == IDX_CARRY) begin
      // Carry out of the add: shift right by one, bump exponent.
`ifdef FP_NORM_ROUND_NEAREST_EN
      // Guard is the bit dropped by the right shift; frac[0] is mant[1].
      round_up    = s1_mant_q[0] & (s1_sticky_q | s1_mant_q[1]);
      round_carry = round_up & (&s1_mant_q[FW:1]);
      frac_tmp    = s1_mant_q[FW:1] + FW'(round_up);
`else
      frac_tmp    = s1_mant_q[FW:1];
`endif
      exp_ext = {1'b0, s1_exp_q} + (EXP_W+1)'(1) + (EXP_W+1)'(round_carry);
      if (exp_ext >= EXP_SAT) begin
        calc_res.exp  = EXP_ONES;
        calc_ovf      = 1'b1;
      end else begin
        calc_res.exp  = exp_ext[EXP_W-1:0];
        calc_res.frac = frac_tmp;
      end
    end else if (s1_idx_q == IDX_HIDDEN) begin
      calc_res.exp  = s1_exp_q;
      calc_res.frac = s1_mant_q[FW-1:0];
    end else begin
      // Cancellation: left-shift the leading one up to the hidden position.
      shift = IDX_HIDDEN - s1_idx_q;
      if ({1'b0, s1_exp_q} <= (EXP_W+1)'(shift)) begin
        calc_unf = 1'b1;
      end else begin
        exp_ext       = {1'b0, s1_exp_q} - (EXP_W+1)'(shift);
        calc_res.exp  = exp_ext[EXP_W-1:0];
        calc_res.frac = FW'(s1_mant_q << shift);
      end
    end
  end

  // ---------------- S2 registers ----------------
  logic out_valid_q, out_valid_d;
  fp_sp res_q, res_d;
  logic ovf_q, ovf_d, unf_q, unf_d;

  always_comb begin
    out_valid_d = out_valid_q;
    res_d       = res_q;
    ovf_d       = ovf_q;
    unf_d       = unf_q;
    // Holding everything when !advance keeps out_* stable under backpressure.
    if (advance) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        res_d = calc_res;
        ovf_d = calc_ovf;
        unf_d = calc_unf;
      end
    end
  end

  // NOTE: sequential state uses non-blocking '<='; the datapath registers are
  // reset too, because the outputs must read as zero straight out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_sign_q   <= 1'b0;
      s1_exp_q    <= '0;
      s1_mant_q   <= '0;
      s1_idx_q    <= '0;
`ifdef FP_NORM_ROUND_NEAREST_EN
      s1_sticky_q <= 1'b0;
`endif
      out_valid_q <= 1'b0;
      res_q       <= '0;
      ovf_q       <= 1'b0;
      unf_q       <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_sign_q   <= s1_sign_d;
      s1_exp_q    <= s1_exp_d;
      s1_mant_q   <= s1_mant_d;
      s1_idx_q    <= s1_idx_d;
`ifdef FP_NORM_ROUND_NEAREST_EN
      s1_sticky_q <= s1_sticky_d;
`endif
      out_valid_q <= out_valid_d;
      res_q       <= res_d;
      ovf_q       <= ovf_d;
      unf_q       <= unf_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_sign  = res_q.sign;
  assign out_exp   = res_q.exp;
  assign out_frac  = res_q.frac;
  assign out_ovf   = ovf_q;
  assign out_unf   = unf_q;

endmodule : fp_normalizer

// File: tb/tb_fp_normalizer.sv
// -----------------------------------------------------------------------------
// tb_fp_normalizer
// Scoreboard bench for fp_normalizer: the driver pushes the hand-computed
// expected result of each beat as it is accepted; a monitor pops and compares
// on every output handshake and checks that outputs hold during stalls.
// Rounding vectors follow FP_NORM_ROUND_NEAREST_EN.
// -----------------------------------------------------------------------------
module tb_fp_normalizer;

  localparam int MANT_W = 25;
  localparam int EXP_W  = 8;
  localparam int FW     = MANT_W - 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid, in_ready, in_sign, in_sticky;
  logic [EXP_W-1:0]  in_exp;
  logic [MANT_W-1:0] in_mant;
  logic              out_valid, out_ready, out_sign, out_ovf, out_unf;
  logic [EXP_W-1:0]  out_exp;
  logic [FW-1:0]     out_frac;

  always #5 clk = ~clk;

  fp_normalizer #(.MANT_W(MANT_W), .EXP_W(EXP_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sign   (in_sign),
    .in_exp    (in_exp),
    .in_mant   (in_mant),
    .in_sticky (in_sticky),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sign  (out_sign),
    .out_exp   (out_exp),
    .out_frac  (out_frac),
    .out_ovf   (out_ovf),
    .out_unf   (out_unf)
  );

  typedef struct {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [FW-1:0]    frac;
    logic             ovf;
    logic             unf;
  } res_t;

  typedef struct {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [MANT_W-1:0] mant;
    logic              sticky;
    res_t              res;
  } vec_t;

  res_t sb[$];
  vec_t vecs[$];
  int   checks = 0;
  int   failures = 0;
  int   pushed = 0;
  int   popped = 0;
  int   wait_cycles = 0;
  bit   saw_in_ready_low = 0;
  bit   held_v = 0;
  res_t held, cur, exp_r;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic cmp_res(input string tag, input res_t a, input res_t e);
    check({tag, "_sign"}, a.sign, e.sign);
    check({tag, "_exp"},  a.exp,  e.exp);
    check({tag, "_frac"}, a.frac, e.frac);
    check({tag, "_ovf"},  a.ovf,  e.ovf);
    check({tag, "_unf"},  a.unf,  e.unf);
  endtask

  function automatic vec_t mk(input logic s, input logic [7:0] e, input logic [24:0] m,
                              input logic st, input logic rs, input logic [7:0] re,
                              input logic [22:0] rf, input logic ro, input logic ru);
    vec_t v;
    v.sign = s; v.exp = e; v.mant = m; v.sticky = st;
    v.res.sign = rs; v.res.exp = re; v.res.frac = rf; v.res.ovf = ro; v.res.unf = ru;
    return v;
  endfunction

  // Caller must be at posedge+1; returns at posedge+1 after the beat is taken.
  task automatic send(input vec_t v);
    int n;
    in_valid  = 1'b1;
    in_sign   = v.sign;
    in_exp    = v.exp;
    in_mant   = v.mant;
    in_sticky = v.sticky;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    wait_cycles += n;
    check("send_in_ready", in_ready, 1'b1);
    sb.push_back(v.res);
    pushed++;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      n++;
      @(negedge clk);
    end
    check("drain_queue_empty", sb.size(), 0);
  endtask

  // Monitor: a beat transfers when out_valid & out_ready are seen mid-cycle.
  initial begin
    forever begin
      @(negedge clk);
      cur.sign = out_sign; cur.exp = out_exp; cur.frac = out_frac;
      cur.ovf = out_ovf;   cur.unf = out_unf;
      if (!in_ready) saw_in_ready_low = 1'b1;
      if (rst) begin
        held_v = 1'b0;
      end else if (out_valid) begin
        if (held_v) cmp_res("stall_hold", cur, held);
        if (out_ready) begin
          check("beat_expected", sb.size() != 0, 1'b1);
          if (sb.size() != 0) begin
            exp_r = sb.pop_front();
            popped++;
            cmp_res($sformatf("beat%0d", popped), cur, exp_r);
          end
          held_v = 1'b0;
        end else begin
          held   = cur;
          held_v = 1'b1;
        end
      end else begin
        held_v = 1'b0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  initial begin
    vecs.push_back(mk(0, 100, 25'h0800000, 0,  0, 100, 23'h000000, 0, 0)); // 0
    vecs.push_back(mk(0, 254, 25'h1800000, 0,  0, 255, 23'h000000, 1, 0)); // 1 ovf
    vecs.push_back(mk(0,  10, 25'h1800000, 0,  0,  11, 23'h400000, 0, 0)); // 2
    vecs.push_back(mk(0,  30, 25'h0000001, 0,  0,   7, 23'h000000, 0, 0)); // 3
    vecs.push_back(mk(0,  23, 25'h0000001, 0,  0,   0, 23'h000000, 0, 1)); // 4 unf
    vecs.push_back(mk(1,  77, 25'h0000000, 0,  1,   0, 23'h000000, 0, 0)); // 5 zero
    vecs.push_back(mk(0, 255, 25'h0400001, 0,  0, 255, 23'h400001, 0, 0)); // 6 inf/nan
    vecs.push_back(mk(1, 120, 25'h0123456, 0,  1, 117, 23'h11A2B0, 0, 0)); // 7 shift 3
`ifdef FP_NORM_ROUND_NEAREST_EN
    vecs.push_back(mk(0,  50, 25'h1FFFFFF, 0,  0,  52, 23'h000000, 0, 0)); // 8 round carry
`else
    vecs.push_back(mk(0,  50, 25'h1FFFFFF, 0,  0,  51, 23'h7FFFFF, 0, 0)); // 8 truncate
`endif
    vecs.push_back(mk(1,   1, 25'h0400000, 0,  1,   0, 23'h000000, 0, 1)); // 9 exp==shift
    vecs.push_back(mk(0,   2, 25'h0400000, 0,  0,   1, 23'h000000, 0, 0)); // 10 exp==shift+1
`ifdef FP_NORM_ROUND_NEAREST_EN
    vecs.push_back(mk(0, 253, 25'h1000001, 1,  0, 254, 23'h000001, 0, 0)); // 11 sticky round
`else
    vecs.push_back(mk(0, 253, 25'h1000001, 1,  0, 254, 23'h000000, 0, 0)); // 11 sticky ignored
`endif

    // Reset state.
    rst = 1'b1; in_valid = 1'b0; in_sign = 1'b0; in_exp = '0; in_mant = '0;
    in_sticky = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_sign",  out_sign,  1'b0);
    check("rst_out_exp",   out_exp,   0);
    check("rst_out_frac",  out_frac,  0);
    check("rst_out_ovf",   out_ovf,   1'b0);
    check("rst_out_unf",   out_unf,   1'b0);
    check("rst_in_ready",  in_ready,  1'b1);
    @(negedge clk);
    rst = 1'b0;

    // Latency: accepted beat shows on out_valid in the second cycle after acceptance.
    sync();
    send(vecs[0]);
    @(negedge clk);
    check("latency_cycle1_out_valid", out_valid, 1'b0);
    @(negedge clk);
    check("latency_cycle2_out_valid", out_valid, 1'b1);
    drain();

    // Remaining vectors back to back with out_ready high: no input waits.
    sync();
    wait_cycles = 0;
    for (int i = 1; i < vecs.size(); i++) send(vecs[i]);
    check("full_throughput_waits", wait_cycles, 0);
    drain();

    // Stall: 8 beats back to back, out_ready low for stream cycles 3-5.
    sync();
    saw_in_ready_low = 1'b0;
    fork
      begin
        for (int i = 0; i < 8; i++) send(vecs[i]);
      end
      begin
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();
    check("stall_in_ready_dropped", saw_in_ready_low, 1'b1);

    // Asynchronous reset mid-stream: two beats in flight are discarded.
    sync();
    in_valid = 1'b1; in_sign = vecs[2].sign; in_exp = vecs[2].exp;
    in_mant = vecs[2].mant; in_sticky = vecs[2].sticky;
    @(posedge clk);
    @(posedge clk);
    #2;
    check("pre_reset_out_valid", out_valid, 1'b1);
    rst = 1'b1;
    in_valid = 1'b0;
    #1;
    check("async_reset_out_valid", out_valid, 1'b0);
    check("async_reset_in_ready", in_ready, 1'b1);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("post_reset_no_beat", out_valid, 1'b0);
    end

    // Recovery after reset.
    sync();
    send(vecs[7]);
    drain();
    check("beats_in_equals_out", popped, pushed);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_fp_normalizer
